// File: rtl/uart_rx_axis_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_axis_if
// Purpose  : AXI4-Stream word channel carrying received UART words.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_axis.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_axis
// Purpose  : 8N1-style UART receiver (LSB first) feeding an AXI4-Stream master.
//            Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_axis #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_axis_if.master        m_axis,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_rxd_meta, r_rxd_s;
    logic [18:0]           r_period, w_period_nxt;
    logic [18:0]           r_cnt, w_cnt_nxt;
    logic [6:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_shift_in;
    logic [DATA_WIDTH-1:0] r_tdata, w_tdata_nxt;
    logic                  r_tvalid, w_tvalid_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_ovr, w_ovr_nxt;
    logic                  r_ferr, w_ferr_nxt;
    logic                  w_bit;
    logic                  w_expire;
    logic [18:0]           w_first_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision is taken one cycle past mid-bit so three samples straddle it.
    logic [1:0] r_hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= 2'b11;
        else        r_hist <= {r_hist[0], r_rxd_s};
    end
    assign w_bit        = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxd_s) | (r_hist[0] & r_rxd_s);
    assign w_first_load = {1'b0, prescale, 2'b00};
`else
    assign w_bit        = r_rxd_s;
    assign w_first_load = {1'b0, prescale, 2'b00} - 19'd1;
`endif

    generate
        if (DATA_WIDTH == 1) begin : g_shift_w1
            assign w_shift_in = w_bit;
        end else begin : g_shift_wn
            assign w_shift_in = {w_bit, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    assign w_expire = (r_cnt == 19'd0);

    always_comb begin
        w_state_nxt   = r_state;
        w_period_nxt  = r_period;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_tdata_nxt   = r_tdata;
        w_tvalid_nxt  = r_tvalid & ~m_axis.tready;
        w_busy_nxt    = r_busy;
        w_ovr_nxt     = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rxd_s && (prescale != 16'd0)) begin
                    w_period_nxt = {prescale, 3'b000};
                    w_cnt_nxt    = w_first_load;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - 19'd1;
                end else if (w_bit) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt     = r_period - 19'd1;
                    w_bit_cnt_nxt = 7'(DATA_WIDTH);
                    w_state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - 19'd1;
                end else begin
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = r_bit_cnt - 7'd1;
                    w_cnt_nxt     = r_period - 19'd1;
                    if (r_bit_cnt == 7'd1) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - 19'd1;
                end else begin
                    if (w_bit) begin
                        w_tdata_nxt  = r_shift;
                        w_tvalid_nxt = 1'b1;
                        w_ovr_nxt    = r_tvalid & ~m_axis.tready;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_period  <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_period  <= w_period_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tdata   <= w_tdata_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_busy    <= w_busy_nxt;
            r_ovr     <= w_ovr_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign busy          = r_busy;
    assign overrun_error = r_ovr;
    assign frame_error   = r_ferr;

endmodule
`default_nettype wire
